controle_relogio: RTL
=====================

CONTROLE_RELOGIO -- requirements
Module: controle_relogio

Interface
REQ-001 Parameter DIV, default 1000, clock cycles per one-unit time tick; legal range 2..2^20.
REQ-002 Parameter TW, default 20, width of the internal tick counter; SHALL satisfy 2^TW >= DIV.
REQ-003 Port clock, in, 1, single system clock; all state SHALL update on posedge clock.
REQ-004 Port reset, in, 1, synchronous, active-high reset.
REQ-005 Port iniciar, in, 1, level; a rising edge starts or restarts a game.
REQ-006 Port jogada, in, 1, level; a rising edge means the active player finished a move.
REQ-007 Port pausa, in, 1, level; a rising edge toggles pause.
REQ-008 Port fim_branco, in, 1, expired flag from the white player's time counter.
REQ-009 Port fim_preto, in, 1, expired flag from the black player's time counter.
REQ-010 Ports zera_branco and zera_preto, out, 1 each, synchronous clear to each player's time counter.
REQ-011 Ports conta_branco and conta_preto, out, 1 each, one-cycle tick pulses to the active player's counter.
REQ-012 Ports decresce_branco and decresce_preto, out, 1 each, one-cycle move-increment pulses to a counter.
REQ-013 Port vez, out, 1, active player: 0 is white, 1 is black.
REQ-014 Port fim_jogo, out, 1, high while in FIM.
REQ-015 Port perdedor, out, 1, player whose time expired; valid while fim_jogo=1.
REQ-016 Port estado, out, 3, current FSM state encoding, for debug.

Function
REQ-017 FSM states SHALL be INICIAL=0, PREPARA=1, JOGANDO=2, PAUSADO=3, FIM=4; all other codes SHALL go to INICIAL.
REQ-018 Edges on iniciar, jogada and pausa SHALL be detected by registering the previous level; edge = current & ~previous; every action SHALL occur one cycle after the edge sample.
REQ-019 An iniciar edge in any state SHALL go to PREPARA, which has priority over all other events.
REQ-020 PREPARA SHALL last exactly 1 cycle: zera_branco=zera_preto=1, vez<=0, tick counter<=0, then go to JOGANDO.
REQ-021 In JOGANDO the tick counter SHALL count 0..DIV-1 and wrap; on wrap, conta_<vez> SHALL pulse 1 cycle and the other conta output SHALL stay 0.
REQ-022 On a jogada edge in JOGANDO: decresce_<vez> SHALL pulse 1 cycle, vez SHALL toggle, and the tick counter SHALL go to 0.
REQ-023 If a jogada edge and a tick wrap coincide, the jogada SHALL win and no conta pulse is issued that cycle.
REQ-024 In JOGANDO, if fim of the active player is 1: go to FIM, perdedor<=vez, no decresce pulse; this SHALL beat a same-cycle jogada.
REQ-025 fim of the inactive player SHALL be ignored.
REQ-026 A pausa edge SHALL toggle JOGANDO<->PAUSADO.
REQ-027 In PAUSADO the tick counter SHALL hold, jogada SHALL be ignored, and no conta or decresce pulse is issued.
REQ-028 pausa and jogada edges SHALL be ignored in INICIAL and FIM.
REQ-029 FIM SHALL hold until an iniciar edge; vez and perdedor SHALL be frozen in FIM.
REQ-030 At most one of conta_* and decresce_* SHALL be high in any cycle.

Reset
REQ-031 On reset=1: state=INICIAL, vez=0, perdedor=0, fim_jogo=0, tick counter=0, edge registers=0, all zera/conta/decresce outputs=0.
REQ-032 Reset SHALL override every input, including mid-tick, mid-pause and in FIM.
REQ-033 An input already high when reset releases SHALL NOT count as an edge.

Configuration
REQ-034 Macro RELOGIO_INCREMENTO_EN defined: the move increment is enabled and decresce pulses occur per REQ-022.
REQ-035 RELOGIO_INCREMENTO_EN undefined: decresce_branco and decresce_preto SHALL be constant 0; turn switch and tick reset still occur.

Structure
REQ-036 Shared package relogio_pkg SHALL hold the state encodings, the white/black constants and the default DIV.
REQ-037 Sub-module gerador_tick SHALL hold the tick counter, with inputs habilita and limpa and output tick.

Verification
REQ-038 DIV=4: reset, iniciar edge -> 1 cycle of zera_*=1; then conta_branco pulses every 4 cycles; conta_preto=0.
REQ-039 jogada edge with vez=0 -> decresce_branco 1 cycle (macro on); vez=1; next conta_preto exactly 4 cycles later.
REQ-040 jogada edge on the tick-wrap cycle -> decresce only, no conta that cycle; tick restarts from 0.
REQ-041 pausa after 2 counts, wait 10 cycles, pausa again -> no pulses while paused; next conta 2 cycles after resume.
REQ-042 fim_branco=1 with vez=0 and a same-cycle jogada -> FIM, perdedor=0, no decresce; fim_preto=1 with vez=0 ignored.
REQ-043 Macro undefined: the REQ-039 stimulus -> decresce_* stay 0 and vez still toggles; reset asserted in FIM -> INICIAL, all outputs 0.

Source files
------------

// File: rtl/relogio_pkg.sv
// Shared constants for the chess-clock controller: FSM state codes,
// player identifiers and the default tick divider.
package relogio_pkg;

    // FSM state codes, also exposed on the estado debug port
    localparam logic [2:0] INICIAL = 3'd0;
    localparam logic [2:0] PREPARA = 3'd1;
    localparam logic [2:0] JOGANDO = 3'd2;
    localparam logic [2:0] PAUSADO = 3'd3;
    localparam logic [2:0] FIM     = 3'd4;

    // Player identifiers as carried on vez and perdedor
    localparam logic BRANCO = 1'b0;
    localparam logic PRETO  = 1'b1;

    // Default clock cycles per time unit and matching counter width
    localparam int DIV_PADRAO = 1000;
    localparam int TW_PADRAO  = 20;

endpackage

// File: rtl/controle_relogio_gerador_tick.sv
// Tick generator: counts 0..DIV-1 while enabled and flags the wrap cycle.
// limpa forces the count back to zero and suppresses the tick that cycle.
module gerador_tick
    import relogio_pkg::*;
#(
    parameter int DIV = DIV_PADRAO,
    parameter int TW  = TW_PADRAO
) (
    input  logic clock,
    input  logic reset,
    input  logic habilita,
    input  logic limpa,
    output logic tick
);

    localparam logic [TW-1:0] ULTIMO = TW'(DIV - 1);

    logic [TW-1:0] contagem;

    assign tick = habilita && !limpa && (contagem == ULTIMO);

    // Advance the count while enabled, wrapping on the last value; hold otherwise
    always_ff @(posedge clock) begin
        if (reset || limpa) begin
            contagem <= '0;
        end else if (habilita) begin
            contagem <= tick ? '0 : contagem + TW'(1);
        end
    end

endmodule

// File: rtl/controle_relogio.sv
// Chess-clock game controller. Detects rising edges on iniciar, jogada and
// pausa, sequences the game FSM and drives clear, tick and move-increment
// pulses to the two player time counters.
// Optional macro RELOGIO_INCREMENTO_EN enables the decresce_* move-increment
// pulses; without it those outputs stay constant 0.
module controle_relogio
    import relogio_pkg::*;
#(
    parameter int DIV = DIV_PADRAO,
    parameter int TW  = TW_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       pausa,
    input  logic       fim_branco,
    input  logic       fim_preto,
    output logic       zera_branco,
    output logic       zera_preto,
    output logic       conta_branco,
    output logic       conta_preto,
    output logic       decresce_branco,
    output logic       decresce_preto,
    output logic       vez,
    output logic       fim_jogo,
    output logic       perdedor,
    output logic [2:0] estado
);

`ifdef RELOGIO_INCREMENTO_EN
    localparam logic INCREMENTO_EN = 1'b1;
`else
    localparam logic INCREMENTO_EN = 1'b0;
`endif

    logic [2:0] estado_atual;
    logic       vez_atual;
    logic       perdedor_atual;

    logic       iniciar_ant;
    logic       jogada_ant;
    logic       pausa_ant;
    logic       armado;

    logic       iniciar_borda;
    logic       jogada_borda;
    logic       pausa_borda;
    logic       fim_ativo;
    logic       habilita;
    logic       limpa;
    logic       tick;

    // armado stays low for the first cycle after reset so a level that was
    // already high while reset was asserted is absorbed, not seen as an edge
    assign iniciar_borda = armado && iniciar && !iniciar_ant;
    assign jogada_borda  = armado && jogada  && !jogada_ant;
    assign pausa_borda   = armado && pausa   && !pausa_ant;

    assign fim_ativo = (vez_atual == PRETO) ? fim_preto : fim_branco;

    // The counter runs only in an uninterrupted playing cycle; a move or the
    // one-cycle preparation state restarts it from zero
    assign habilita = (estado_atual == JOGANDO) && !iniciar_borda && !fim_ativo;
    assign limpa    = (estado_atual == PREPARA) || (habilita && jogada_borda);

    gerador_tick #(
        .DIV (DIV),
        .TW  (TW)
    ) gerador (
        .clock    (clock),
        .reset    (reset),
        .habilita (habilita),
        .limpa    (limpa),
        .tick     (tick)
    );

    // Remember the previous input levels for rising-edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            iniciar_ant <= 1'b0;
            jogada_ant  <= 1'b0;
            pausa_ant   <= 1'b0;
            armado      <= 1'b0;
        end else begin
            iniciar_ant <= iniciar;
            jogada_ant  <= jogada;
            pausa_ant   <= pausa;
            armado      <= 1'b1;
        end
    end

    // Game FSM plus the registered one-cycle tick and move pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_atual    <= INICIAL;
            vez_atual       <= BRANCO;
            perdedor_atual  <= BRANCO;
            conta_branco    <= 1'b0;
            conta_preto     <= 1'b0;
            decresce_branco <= 1'b0;
            decresce_preto  <= 1'b0;
        end else begin
            conta_branco    <= 1'b0;
            conta_preto     <= 1'b0;
            decresce_branco <= 1'b0;
            decresce_preto  <= 1'b0;
            if (iniciar_borda) begin
                estado_atual <= PREPARA;
            end else begin
                case (estado_atual)
                    INICIAL, FIM: begin
                        estado_atual <= estado_atual;
                    end
                    PREPARA: begin
                        vez_atual    <= BRANCO;
                        estado_atual <= JOGANDO;
                    end
                    JOGANDO: begin
                        if (fim_ativo) begin
                            estado_atual   <= FIM;
                            perdedor_atual <= vez_atual;
                        end else begin
                            if (jogada_borda) begin
                                decresce_branco <= INCREMENTO_EN && (vez_atual == BRANCO);
                                decresce_preto  <= INCREMENTO_EN && (vez_atual == PRETO);
                                vez_atual       <= ~vez_atual;
                            end else if (tick) begin
                                conta_branco <= (vez_atual == BRANCO);
                                conta_preto  <= (vez_atual == PRETO);
                            end
                            if (pausa_borda) begin
                                estado_atual <= PAUSADO;
                            end
                        end
                    end
                    PAUSADO: begin
                        if (pausa_borda) begin
                            estado_atual <= JOGANDO;
                        end
                    end
                    default: begin
                        estado_atual <= INICIAL;
                    end
                endcase
            end
        end
    end

    assign zera_branco = (estado_atual == PREPARA);
    assign zera_preto  = (estado_atual == PREPARA);
    assign fim_jogo    = (estado_atual == FIM);
    assign vez         = vez_atual;
    assign perdedor    = perdedor_atual;
    assign estado      = estado_atual;

endmodule
